// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, port ids and latency bounds shared by
// the memory arbiter and its winner-selection helper.
package mem_arb_pkg;

  typedef logic [1:0] arbState_t;

  localparam arbState_t S_IDLE  = 2'd0;
  localparam arbState_t S_ISSUE = 2'd1;
  localparam arbState_t S_WAIT  = 2'd2;
  localparam arbState_t S_DONE  = 2'd3;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  function automatic logic latencyOk(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection for the two requesters.
// MEM_ARB_DATA_PRIORITY_EN gives port 1 a fixed tie win; else round-robin.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic lastGnt,
  output logic winner
);

`ifdef MEM_ARB_DATA_PRIORITY_EN
  logic unusedLastGnt;
  assign unusedLastGnt = lastGnt;

  always_comb begin
    winner = PORT_INSTR;
    unique case (1'b1)
      req1:    winner = PORT_DATA;
      default: winner = PORT_INSTR;
    endcase
  end
`else
  always_comb begin
    winner = PORT_INSTR;
    unique case (1'b1)
      (req0 & req1):  winner = ~lastGnt;
      (req1 & ~req0): winner = PORT_DATA;
      default:        winner = PORT_INSTR;
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports.
// Tie policy selected by MEM_ARB_DATA_PRIORITY_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (!latencyOk(MEM_LATENCY)) begin : gBadLatency
    $error("mem_arbiter: MEM_LATENCY %0d outside %0d..%0d",
           MEM_LATENCY, LAT_MIN, LAT_MAX);
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arbState_t        state;
  logic             lastGnt;
  logic             curPort;
  cmd_t             cmd;
  cmd_t             reqCmd;
  logic [CNT_W-1:0] cnt;
  logic             winner;
  logic             anyReq;
  logic             inIssue;
  logic             inDone;

  mem_arb_pick uPick (
    .req0    (req0),
    .req1    (req1),
    .lastGnt (lastGnt),
    .winner  (winner)
  );

  assign anyReq = req0 | req1;
  assign reqCmd = (winner == PORT_DATA) ?
                  {we1, addr1, wdata1} :
                  {we0, addr0, wdata0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lastGnt <= PORT_DATA;
      curPort <= PORT_INSTR;
      cmd     <= '0;
      cnt     <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (anyReq) begin
            curPort <= winner;
            lastGnt <= winner;
            cmd     <= reqCmd;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= LAT_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            // memory data is valid only on the final wait cycle
            if (!cmd.we) begin
              if (curPort == PORT_DATA) rdata1 <= mem_rdata;
              else                      rdata0 <= mem_rdata;
            end
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign inIssue = (state == S_ISSUE);
  assign inDone  = (state == S_DONE);

  assign mem_en    = inIssue;
  assign mem_we    = inIssue & cmd.we;
  assign mem_addr  = inIssue ? cmd.addr  : '0;
  assign mem_wdata = inIssue ? cmd.wdata : '0;

  assign gnt0  = inIssue & (curPort == PORT_INSTR);
  assign gnt1  = inIssue & (curPort == PORT_DATA);
  assign done0 = inDone  & (curPort == PORT_INSTR);
  assign done1 = inDone  & (curPort == PORT_DATA);
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a
// transaction-level arbitration model and a fixed-latency memory model.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, done0, gnt1, done1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic        reqV [2] = '{1'b0, 1'b0};
  logic        weV [2] = '{1'b0, 1'b0};
  logic [31:0] addrV [2] = '{32'h0, 32'h0};
  logic [31:0] wdataV [2] = '{32'h0, 32'h0};

  assign req0 = reqV[0];
  assign we0 = weV[0];
  assign addr0 = addrV[0];
  assign wdata0 = wdataV[0];
  assign req1 = reqV[1];
  assign we1 = weV[1];
  assign addr1 = addrV[1];
  assign wdata1 = wdataV[1];

  mem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tcmd_t;

  typedef struct {
    int          gc;
    int          dc;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } txn_t;

  txn_t  gq[$];
  txn_t  dq[$];
  tcmd_t dirQ0[$];
  tcmd_t dirQ1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pct = 0;
  int rndBudget = 0;
  int rndIssued = 0;

  int          lastG = 1;
  int          freeAt = 0;
  int          bFrom = 0;
  int          bTo = -1;
  logic [31:0] lastRd [2] = '{32'h0, 32'h0};
  logic [31:0] modelMem [64] = '{default: 32'h0};

  logic [31:0] memArr [64] = '{default: 32'h0};
  logic [31:0] pendData = 32'h0;
  int          pendCnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Memory: writes land at the strobe, read data appears LAT cycles later
  always @(posedge clk) begin
    mem_rdata <= $urandom;
    if (pendCnt == 1) mem_rdata <= pendData;
    if (pendCnt > 0) pendCnt <= pendCnt - 1;
    if (mem_en) begin
      if (mem_we) memArr[mem_addr[7:2]] <= mem_wdata;
      else if (LAT == 1) mem_rdata <= memArr[mem_addr[7:2]];
      else begin
        pendData <= memArr[mem_addr[7:2]];
        pendCnt <= LAT - 1;
      end
    end
  end

  // Reference: one transaction at a time, fixed timing from the sample cycle
  always @(posedge clk) begin : model
    int   n;
    int   w;
    txn_t t;
    n = cyc;
    if (!rst_n) begin
      gq.delete();
      dq.delete();
      lastG = 1;
      lastRd[0] = 32'h0;
      lastRd[1] = 32'h0;
      freeAt = n + 1;
      bFrom = 0;
      bTo = -1;
    end else if (n >= freeAt && (reqV[0] || reqV[1])) begin
      if (reqV[0] && reqV[1]) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
        w = 1;
`else
        w = 1 - lastG;
`endif
      end else begin
        w = reqV[1] ? 1 : 0;
      end
      lastG = w;
      t.gc = n + 1;
      t.dc = n + 2 + LAT;
      t.port = w;
      t.we = weV[w];
      t.addr = addrV[w];
      t.wdata = wdataV[w];
      if (weV[w]) modelMem[addrV[w][7:2]] = wdataV[w];
      else lastRd[w] = modelMem[addrV[w][7:2]];
      t.rd0 = lastRd[0];
      t.rd1 = lastRd[1];
      freeAt = n + 3 + LAT;
      bFrom = n + 1;
      bTo = n + 2 + LAT;
      gq.push_back(t);
      dq.push_back(t);
    end
    cyc = n + 1;
  end

  always @(negedge clk) begin : monitor
    txn_t t;
    if (rst_n) begin
      chk("busy", busy, (cyc >= bFrom && cyc <= bTo));
      if (gq.size() > 0 && gq[0].gc < cyc) begin
        chk("grant missing", 0, 1);
        void'(gq.pop_front());
      end
      if (gnt0 || gnt1 || mem_en) begin
        if (gq.size() == 0) chk("unexpected grant", {gnt0, gnt1, mem_en}, 0);
        else begin
          t = gq.pop_front();
          chk("gnt cycle", cyc, t.gc);
          chk("gnt0", gnt0, t.port == 0);
          chk("gnt1", gnt1, t.port == 1);
          chk("mem_en", mem_en, 1);
          chk("mem_we", mem_we, t.we);
          chk("mem_addr", mem_addr, t.addr);
          if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
        end
      end
      if (dq.size() > 0 && dq[0].dc < cyc) begin
        chk("done missing", 0, 1);
        void'(dq.pop_front());
      end
      if (done0 || done1) begin
        if (dq.size() == 0) chk("unexpected done", {done0, done1}, 0);
        else begin
          t = dq.pop_front();
          chk("done cycle", cyc, t.dc);
          chk("done0", done0, t.port == 0);
          chk("done1", done1, t.port == 1);
          chk("rdata0", rdata0, t.rd0);
          chk("rdata1", rdata1, t.rd1);
        end
      end
    end
  end

  task automatic startReq(input int p, input tcmd_t c);
    weV[p] = c.we;
    addrV[p] = c.addr;
    wdataV[p] = c.wdata;
    reqV[p] = 1'b1;
  endtask

  // Requesters: hold until gnt, drop in the following cycle
  initial begin : driver
    logic  g [2];
    tcmd_t c;
    forever begin
      @(negedge clk);
      g[0] = gnt0;
      g[1] = gnt1;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (reqV[p]) begin
          if (g[p]) reqV[p] = 1'b0;
        end else if (p == 0 && dirQ0.size() > 0) begin
          startReq(p, dirQ0.pop_front());
        end else if (p == 1 && dirQ1.size() > 0) begin
          startReq(p, dirQ1.pop_front());
        end else if (rndIssued < rndBudget &&
                     $urandom_range(0, 99) < pct) begin
          c.we = 1'($urandom_range(0, 1));
          c.addr = $urandom;
          c.wdata = $urandom;
          startReq(p, c);
          rndIssued++;
        end
      end
    end
  end

  task automatic drain(input string nm);
    int k = 0;
    while ((gq.size() > 0 || dq.size() > 0 || reqV[0] || reqV[1] ||
            dirQ0.size() > 0 || dirQ1.size() > 0 ||
            rndIssued < rndBudget) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, k >= 4000, 0);
  endtask

  task automatic waitGnt(input int p);
    int k = 0;
    while (!(p == 0 ? gnt0 : gnt1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait gnt", k >= 100, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", {gnt0, gnt1, done0, done1, mem_en, mem_we, busy}, 0);
    chk("reset rdata", {rdata0, rdata1}, 0);
    chk("reset mem bus", {mem_addr, mem_wdata}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    dirQ1.push_back('{1'b1, 32'h10, 32'hDEADBEEF});
    drain("drain seed");
    dirQ0.push_back('{1'b0, 32'h10, 32'h0});
    drain("drain read0");
    dirQ1.push_back('{1'b1, 32'h40, 32'h12345678});
    drain("drain write1");

    for (int i = 0; i < 4; i++) begin
      dirQ0.push_back('{1'b0, 32'h40, 32'h0});
      dirQ1.push_back('{1'b0, 32'h10, 32'h0});
    end
    drain("drain tie");

    pct = 30;
    rndBudget += 60;
    drain("drain random");
    pct = 100;
    rndBudget += 24;
    drain("drain hot");
    pct = 0;

    dirQ0.push_back('{1'b0, 32'h40, 32'h0});
    waitGnt(0);
    @(posedge clk);
    #2 dirQ1.push_back('{1'b0, 32'h10, 32'h0});
    drain("drain late req");

    dirQ1.push_back('{1'b1, 32'h80, 32'hA5A5A5A5});
    drain("drain prep write");
    dirQ0.push_back('{1'b0, 32'h80, 32'h0});
    drain("drain prep read");
    dirQ0.push_back('{1'b0, 32'h10, 32'h0});
    waitGnt(0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("busy after reset", busy, 0);
    chk("rdata0 cleared", rdata0, 0);
    chk("no done after reset", {done0, done1}, 0);
    dirQ0.push_back('{1'b0, 32'h80, 32'h0});
    drain("drain after reset");

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
